// File: rtl/valid_pacer.sv
// valid_pacer: buffers ready/valid requests in a small FIFO and issues them as single-cycle
// o_valid pulses spaced at least LATENCY cycles apart. Define VALID_PACER_SVA_EN to bind protocol assertions.
module valid_pacer #(
    parameter int LATENCY = 4,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_enable,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic [DATA_W-1:0]          i_req_data,
    output logic                       o_valid,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_busy,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [GW-1:0]     gap_r;
    logic [GW-1:0]     gap_nxt_s;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              push_s;
    logic              pop_s;
    logic              can_issue_s;
    logic              valid_r;
    logic              busy_r;
    logic [DATA_W-1:0] data_r;

    assign o_req_ready = (count_r != CW'(DEPTH));
    assign push_s      = i_req_valid && o_req_ready;
    assign can_issue_s = i_enable && (count_r != CW'(0));

    assign o_valid = valid_r;
    assign o_data  = data_r;
    assign o_busy  = busy_r;
    assign o_count = count_r;

    // State and gap counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            gap_r   <= GW'(0);
        end else begin
            state_r <= state_nxt_s;
            gap_r   <= gap_nxt_s;
        end
    end

    // Next-state logic; a pop can only be decided in IDLE or on the final GAP cycle.
    always_comb begin
        state_nxt_s = state_r;
        gap_nxt_s   = gap_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (can_issue_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_PULSE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PULSE: begin
                gap_nxt_s   = GW'(LATENCY - 1);
                state_nxt_s = ST_GAP;
            end
            ST_GAP: begin
                gap_nxt_s = gap_r - GW'(1);
                if (gap_r == GW'(1)) begin
                    if (can_issue_s) begin
                        pop_s       = 1'b1;
                        state_nxt_s = ST_PULSE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            default: begin
                gap_nxt_s   = GW'(0);
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FIFO storage and pointers; pointer wrap relies on DEPTH being a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= i_req_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CW'(0);
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered outputs; o_data holds the last issued entry between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
        end else begin
            valid_r <= pop_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            if (pop_s) begin
                data_r <= mem_r[rd_ptr_r];
            end else begin
                data_r <= data_r;
            end
        end
    end

`ifdef VALID_PACER_SVA_EN
    valid_pacer_sva #(
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) u_sva (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (valid_r),
        .push  (push_s),
        .pop   (pop_s),
        .count (count_r)
    );
`endif

endmodule

`ifdef VALID_PACER_SVA_EN
// Protocol checker for valid_pacer: pulse spacing and FIFO occupancy bounds.
module valid_pacer_sva #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 4
) (
    input logic                       clk,
    input logic                       rst_n,
    input logic                       valid,
    input logic                       push,
    input logic                       pop,
    input logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);

    // Each k checks one cycle of the mandatory low window after a pulse.
    for (genvar k = 1; k < LATENCY; k++) begin : g_space
        a_space: assert property (@(posedge clk) disable iff (!rst_n) valid |-> ##k !valid);
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) push |-> (count != CW'(DEPTH)));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) pop |-> (count != CW'(0)));
    a_count_bound:  assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));
endmodule
`endif

// File: tb/tb_valid_pacer.sv
// Bench for valid_pacer: three instances (LATENCY 4, 2, 7) share stimulus; each is checked every
// cycle against an arithmetic model, plus a vector table and directed corner-case sequences.
module tb_valid_pacer;

    function automatic int lat_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 2 : 7);
    endfunction

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       vin;
    logic [7:0] din;
    logic       rdy  [3];
    logic       vo   [3];
    logic [7:0] dout [3];
    logic       busy [3];
    logic [2:0] cnt  [3];

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int L = lat_of(k);
        valid_pacer #(.LATENCY(L), .DATA_W(8), .DEPTH(4)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_enable    (en),
            .i_req_valid (vin),
            .o_req_ready (rdy[k]),
            .i_req_data  (din),
            .o_valid     (vo[k]),
            .o_data      (dout[k]),
            .o_busy      (busy[k]),
            .o_count     (cnt[k])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // Model: queue contents, cycle of last pulse, last issued payload.
    logic [7:0] mq [3][$];
    int         lp [3];
    logic [7:0] ld [3];
    int         n_in  [3];
    int         n_out [3];

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", name, k, cyc, act, exp);
        end
    endtask

    // Check the current cycle's outputs, then advance the model by this cycle's inputs.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int L  = lat_of(k);
            int sz = mq[k].size();
            chk("count", k, 32'(cnt[k]), 32'(sz));
            chk("ready", k, 32'(rdy[k]), 32'(sz != 4));
            chk("valid", k, 32'(vo[k]), 32'(lp[k] == cyc));
            chk("busy",  k, 32'(busy[k]), 32'((cyc >= lp[k]) && (cyc <= lp[k] + L - 1)));
            chk("data",  k, 32'(dout[k]), 32'(ld[k]));
            if (vo[k]) n_out[k]++;
            if (en && (sz != 0) && (cyc >= lp[k] + L - 1)) begin
                ld[k] = mq[k].pop_front();
                lp[k] = cyc + 1;
            end
            if (vin && (sz != 4)) begin
                mq[k].push_back(din);
                n_in[k]++;
            end
        end
        cyc++;
    endtask

    task automatic cycle(input logic e, input logic v, input logic [7:0] d);
        @(posedge clk);
        #1;
        en  = e;
        vin = v;
        din = d;
        #1;
        model_step();
    endtask

    // Asserts reset inside the current cycle (no clock edge) and checks outputs clear at once.
    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        en    = 1'b0;
        vin   = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", k, 32'(vo[k]), 32'(0));
            chk("rst_busy",  k, 32'(busy[k]), 32'(0));
            chk("rst_count", k, 32'(cnt[k]), 32'(0));
            chk("rst_ready", k, 32'(rdy[k]), 32'(1));
            chk("rst_data",  k, 32'(dout[k]), 32'(0));
            mq[k].delete();
            lp[k] = -100;
            ld[k] = 8'h00;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00);
    endtask

    typedef struct packed {
        logic       en;
        logic       vin;
        logic [7:0] din;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_busy;
        logic [2:0] e_count;
        logic       e_ready;
    } vec_t;

    vec_t tbl [18];

    initial begin
        int prev;
        int np;
        logic [7:0] exp_q [4];

        rst_n = 1'b1;
        en    = 1'b0;
        vin   = 1'b0;
        din   = 8'h00;
        for (int k = 0; k < 3; k++) begin
            lp[k] = -100; ld[k] = 8'h00; n_in[k] = 0; n_out[k] = 0;
        end

        // Single push of 0xA5 in cycle 10 on the LATENCY=4 instance.
        for (int i = 0; i < 18; i++) tbl[i] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1};
        tbl[10].vin     = 1'b1;
        tbl[10].din     = 8'hA5;
        tbl[11].e_count = 3'd1;
        tbl[12].e_valid = 1'b1;
        for (int i = 12; i < 18; i++) tbl[i].e_data = 8'hA5;
        for (int i = 12; i < 16; i++) tbl[i].e_busy = 1'b1;

        do_reset();

        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].en, tbl[i].vin, tbl[i].din);
            chk("tbl_valid", 0, 32'(vo[0]),   32'(tbl[i].e_valid));
            chk("tbl_data",  0, 32'(dout[0]), 32'(tbl[i].e_data));
            chk("tbl_busy",  0, 32'(busy[0]), 32'(tbl[i].e_busy));
            chk("tbl_count", 0, 32'(cnt[0]),  32'(tbl[i].e_count));
            chk("tbl_ready", 0, 32'(rdy[0]),  32'(tbl[i].e_ready));
        end

        // Four back-to-back pushes: pulses every 4 cycles, in order.
        prev = -1;
        np   = 0;
        for (int t = 0; t < 28; t++) begin
            if (t < 4) cycle(1'b1, 1'b1, 8'(t + 1));
            else       cycle(1'b1, 1'b0, 8'h00);
            if (vo[0]) begin
                np++;
                chk("b2b_data", 0, 32'(dout[0]), 32'(np));
                if (prev < 0) chk("b2b_first", 0, 32'(t), 32'(2));
                else          chk("b2b_spacing", 0, 32'(t - prev), 32'(4));
                prev = t;
            end
        end
        chk("b2b_pulses", 0, 32'(np), 32'(4));
        chk("b2b_empty",  0, 32'(cnt[0]), 32'(0));

        // Fill with enable low; fifth request held off until the first pop.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'(8'h10 + i));
        cycle(1'b0, 1'b1, 8'h55);
        chk("full_count", 0, 32'(cnt[0]), 32'(4));
        chk("full_ready", 0, 32'(rdy[0]), 32'(0));
        cycle(1'b0, 1'b1, 8'h55);
        chk("full_hold", 0, 32'(cnt[0]), 32'(4));
        cycle(1'b1, 1'b1, 8'h55);
        chk("full_ready_pop", 0, 32'(rdy[0]), 32'(0));
        cycle(1'b1, 1'b1, 8'h55);
        chk("ready_back", 0, 32'(rdy[0]), 32'(1));
        chk("first_pulse", 0, 32'(vo[0]), 32'(1));
        chk("first_data",  0, 32'(dout[0]), 32'(8'h10));
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h55};
        prev = 0;
        np   = 0;
        for (int t = 1; t <= 30; t++) begin
            cycle(1'b1, 1'b0, 8'h00);
            if (vo[0]) begin
                if (np < 4) chk("fill_data", 0, 32'(dout[0]), 32'(exp_q[np]));
                chk("fill_spacing", 0, 32'(t - prev), 32'(4));
                prev = t;
                np++;
            end
        end
        chk("fill_pulses", 0, 32'(np), 32'(4));
        chk("fill_empty",  0, 32'(cnt[0]), 32'(0));

        // Enable dropped during the gap: gap completes, no pulse until enable returns.
        drain(10);
        cycle(1'b0, 1'b1, 8'h31);
        cycle(1'b0, 1'b1, 8'h32);
        cycle(1'b0, 1'b1, 8'h33);
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        chk("gap_pulse", 0, 32'(vo[0]), 32'(1));
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 8'h00);
            chk("gap_busy",  0, 32'(busy[0]), 32'(1));
            chk("gap_valid", 0, 32'(vo[0]), 32'(0));
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 8'h00);
            chk("idle_busy",  0, 32'(busy[0]), 32'(0));
            chk("idle_valid", 0, 32'(vo[0]), 32'(0));
        end
        cycle(1'b1, 1'b0, 8'h00);
        chk("reen_valid0", 0, 32'(vo[0]), 32'(0));
        cycle(1'b1, 1'b0, 8'h00);
        chk("reen_valid1", 0, 32'(vo[0]), 32'(1));
        chk("reen_data",   0, 32'(dout[0]), 32'(8'h32));

        // Reset mid-gap with three entries buffered.
        drain(20);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'(8'h20 + i));
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        chk("pre_rst_pulse", 0, 32'(vo[0]), 32'(1));
        chk("pre_rst_count", 0, 32'(cnt[0]), 32'(3));
        cycle(1'b1, 1'b0, 8'h00);
        chk("pre_rst_gap", 0, 32'(busy[0]), 32'(1));
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 8'h00);
            chk("post_rst_quiet", 0, 32'(vo[0]), 32'(0));
        end

        // Random pushes and enable toggling against the model on all instances.
        for (int k = 0; k < 3; k++) begin
            n_in[k] = 0; n_out[k] = 0;
        end
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        drain(40);
        for (int k = 0; k < 3; k++) begin
            chk("rand_in_out", k, 32'(n_out[k]), 32'(n_in[k]));
            chk("rand_empty",  k, 32'(cnt[k]), 32'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
